// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detect and bubble insert.
// Optional bubble counter: define ID_EX_BUBBLE_CNT_EN.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_pc_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [15:0]       id_imm_i,
  input  logic [ADDR_W-1:0] id_rs_addr_i,
  input  logic [ADDR_W-1:0] id_rt_addr_i,
  input  logic [ADDR_W-1:0] id_rd_addr_i,
  input  logic [8:0]        id_ctrl_i,
  output logic              hazard_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [ADDR_W-1:0] rs_addr_o,
  output logic [ADDR_W-1:0] rt_addr_o,
  output logic [ADDR_W-1:0] rd_addr_o,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [31:0]       bubble_cnt_o,
`endif
  output logic [8:0]        ctrl_o
);

  localparam int MemReadBit = 6;

  logic exIsLoad;
  logic rtNonZero;
  logic rtMatch;
  logic bubble;
  logic load;

  assign exIsLoad  = valid_o & ctrl_o[MemReadBit];
  assign rtNonZero = (rt_addr_o != '0);
  assign rtMatch   = (rt_addr_o == id_rs_addr_i)
                   | (rt_addr_o == id_rt_addr_i);

  // Load-use: EX load writes a register the ID instruction reads.
  assign hazard_o = exIsLoad & rtNonZero & id_valid_i
                  & ~flush_i & rtMatch;

  // Flush beats stall; a hazard bubble only when not frozen.
  assign bubble = flush_i | (~stall_i & hazard_o);
  assign load   = ~flush_i & ~stall_i & ~hazard_o;

  // Control/address state: cleared on bubble, loaded from ID otherwise.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_o   <= 1'b0;
      ctrl_o    <= '0;
      rs_addr_o <= '0;
      rt_addr_o <= '0;
      rd_addr_o <= '0;
    end else if (bubble) begin
      valid_o   <= 1'b0;
      ctrl_o    <= '0;
      rs_addr_o <= '0;
      rt_addr_o <= '0;
      rd_addr_o <= '0;
    end else if (load) begin
      valid_o   <= id_valid_i;
      ctrl_o    <= id_valid_i ? id_ctrl_i : 9'd0;
      rs_addr_o <= id_rs_addr_i;
      rt_addr_o <= id_rt_addr_i;
      rd_addr_o <= id_rd_addr_i;
    end
  end

  // Datapath state: only updated on a real load; bubbles keep old values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_o      <= '0;
      rs_data_o <= '0;
      rt_data_o <= '0;
      imm_o     <= '0;
    end else if (load) begin
      pc_o      <= id_pc_i;
      rs_data_o <= id_rs_data_i;
      rt_data_o <= id_rt_data_i;
      imm_o     <= {{(DATA_W-16){id_imm_i[15]}}, id_imm_i};
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  // Count every edge that inserts a bubble; wraps naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= '0;
    end else if (bubble) begin
      bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized bench for id_ex_stage_reg against a behavioural model.
// Counter checks are active when ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stall;
  logic        idValid;
  logic [31:0] idPc;
  logic [31:0] idRsData;
  logic [31:0] idRtData;
  logic [15:0] idImm;
  logic [4:0]  idRs;
  logic [4:0]  idRt;
  logic [4:0]  idRd;
  logic [8:0]  idCtrl;
  logic        hazard;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] imm;
  logic [4:0]  rsAddr;
  logic [4:0]  rtAddr;
  logic [4:0]  rdAddr;
  logic [8:0]  ctrl;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubbleCnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .stall_i      (stall),
    .id_valid_i   (idValid),
    .id_pc_i      (idPc),
    .id_rs_data_i (idRsData),
    .id_rt_data_i (idRtData),
    .id_imm_i     (idImm),
    .id_rs_addr_i (idRs),
    .id_rt_addr_i (idRt),
    .id_rd_addr_i (idRd),
    .id_ctrl_i    (idCtrl),
    .hazard_o     (hazard),
    .valid_o      (valid),
    .pc_o         (pc),
    .rs_data_o    (rsData),
    .rt_data_o    (rtData),
    .imm_o        (imm),
    .rs_addr_o    (rsAddr),
    .rt_addr_o    (rtAddr),
    .rd_addr_o    (rdAddr),
`ifdef ID_EX_BUBBLE_CNT_EN
    .bubble_cnt_o (bubbleCnt),
`endif
    .ctrl_o       (ctrl)
  );

  int checks = 0;
  int errors = 0;

  // Model of what EX holds.
  bit          known = 0;
  bit          mValid;
  logic [8:0]  mCtrl;
  logic [4:0]  mRs, mRt, mRd;
  logic [31:0] mPc, mRsD, mRtD, mImm;
  logic [31:0] mCnt;

  localparam logic [8:0] CtrlLw = 9'b1_1_1_0_1_0_000;
  localparam logic [8:0] CtrlRw = 9'b1_0_0_0_0_0_000;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic setIn(input bit v, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d,
                       input logic [15:0] im, input logic [8:0] c,
                       input bit fl, input bit st);
    rst      = 1'b1;
    idValid  = v;
    idRs     = s;
    idRt     = t;
    idRd     = d;
    idImm    = im;
    idCtrl   = c;
    flush    = fl;
    stall    = st;
    idPc     = $urandom;
    idRsData = $urandom;
    idRtData = $urandom;
  endtask

  task automatic doBubble();
    mValid = 0;
    mCtrl  = '0;
    mRs    = '0;
    mRt    = '0;
    mRd    = '0;
    mCnt   = mCnt + 1;
  endtask

  // One clock: check hazard before the edge, advance model, check regs.
  task automatic step();
    bit expHaz;
    bit readsRt;
    @(negedge clk);
    readsRt = (mRt == idRs) || (mRt == idRt);
    expHaz  = known && mValid && mCtrl[6] && (mRt != 0)
              && idValid && !flush && readsRt;
    if (known) chk("hazard", {31'd0, hazard}, {31'd0, expHaz});
    if (!rst) begin
      mValid = 0; mCtrl = '0;
      mRs = '0; mRt = '0; mRd = '0;
      mPc = '0; mRsD = '0; mRtD = '0; mImm = '0;
      mCnt = '0;
    end else if (flush) begin
      doBubble();
    end else if (stall) begin
      // everything holds
    end else if (expHaz) begin
      doBubble();
    end else begin
      mValid = idValid;
      mCtrl  = idValid ? idCtrl : 9'd0;
      mRs    = idRs;
      mRt    = idRt;
      mRd    = idRd;
      mPc    = idPc;
      mRsD   = idRsData;
      mRtD   = idRtData;
      mImm   = 32'($signed(idImm));
    end
    @(posedge clk);
    #1;
    known = 1;
    chk("valid",  {31'd0, valid}, {31'd0, mValid});
    chk("ctrl",   {23'd0, ctrl},   {23'd0, mCtrl});
    chk("rsAddr", {27'd0, rsAddr}, {27'd0, mRs});
    chk("rtAddr", {27'd0, rtAddr}, {27'd0, mRt});
    chk("rdAddr", {27'd0, rdAddr}, {27'd0, mRd});
    chk("pc",     pc,     mPc);
    chk("rsData", rsData, mRsD);
    chk("rtData", rtData, mRtD);
    chk("imm",    imm,    mImm);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("bubbleCnt", bubbleCnt, mCnt);
`endif
  endtask

  initial begin
    mCnt = '0;
    // T1: reset with every other input high
    setIn(1, 5'h1f, 5'h1f, 5'h1f, 16'hffff, 9'h1ff, 1, 1);
    rst = 1'b0;
    step();
    chk("rstHazard", {31'd0, hazard}, 32'd0);

    // T2: pass-through with sign-extended immediate
    setIn(1, 5'd3, 5'd4, 5'd5, 16'hfff0, CtrlRw, 0, 0);
    step();
    chk("t2Imm", imm, 32'hfffffff0);
    chk("t2Rd", {27'd0, rdAddr}, 32'd5);

    // T3: lw rt=8 then consumer rs=8
    setIn(1, 5'd1, 5'd8, 5'd0, 16'h0004, CtrlLw, 0, 0);
    step();
    setIn(1, 5'd8, 5'd2, 5'd9, 16'h0001, CtrlRw, 0, 0);
    step();
    chk("t3Bubble", {31'd0, valid}, 32'd0);
    step();
    chk("t3Load", {31'd0, valid}, 32'd1);

    // T4: load to r0 never hazards
    setIn(1, 5'd1, 5'd0, 5'd0, 16'h0000, CtrlLw, 0, 0);
    step();
    setIn(1, 5'd0, 5'd0, 5'd7, 16'h0002, CtrlRw, 0, 0);
    step();
    chk("t4Rd", {27'd0, rdAddr}, 32'd7);

    // T5: hazard setup plus flush
    setIn(1, 5'd1, 5'd8, 5'd0, 16'h0004, CtrlLw, 0, 0);
    step();
    setIn(1, 5'd8, 5'd2, 5'd9, 16'h0001, CtrlRw, 1, 0);
    step();
    chk("t5Bubble", {31'd0, valid}, 32'd0);

    // T6: stall for 3 cycles with changing ID inputs
    setIn(1, 5'd10, 5'd11, 5'd12, 16'h1234, CtrlRw, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      setIn(1, 5'($urandom), 5'($urandom), 5'($urandom),
            16'($urandom), 9'($urandom), 0, 1);
      step();
      chk("t6Hold", {27'd0, rdAddr}, 32'd12);
    end
    setIn(1, 5'd13, 5'd14, 5'd15, 16'h8000, CtrlRw, 0, 0);
    step();
    chk("t6Release", imm, 32'hffff8000);

    // Random traffic; small address space to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      setIn($urandom_range(0, 7) != 0,
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom),
            16'($urandom),
            ($urandom_range(0, 2) == 0) ? CtrlLw : 9'($urandom),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 6) == 0);
      if ($urandom_range(0, 40) == 0) rst = 1'b0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
